// File: rtl/table_port_scheduler.sv
// Arbitrates LOOKUP_PORTS lookup requesters and one update requester onto a single-issue table
// backend, steering in-order responses back via a tag FIFO. Define TABLE_SCHED_STATS_EN for stat counters.
module table_port_scheduler #(
   parameter int KEY_SIZE         = 16,
   parameter int VALUE_SIZE       = 32,
   parameter int LOOKUP_PORTS     = 2,
   parameter int MAX_OUTSTANDING  = 4,
   parameter int UPD_STARVE_LIMIT = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [LOOKUP_PORTS*KEY_SIZE-1:0]   s_lookup_req_index,
   input  logic [LOOKUP_PORTS-1:0]            s_lookup_req_valid,
   output logic [LOOKUP_PORTS-1:0]            s_lookup_req_ready,
   output logic [LOOKUP_PORTS*VALUE_SIZE-1:0] s_lookup_value_data,
   output logic [LOOKUP_PORTS-1:0]            s_lookup_value_valid,
   input  logic [LOOKUP_PORTS-1:0]            s_lookup_value_ready,
   input  logic [KEY_SIZE-1:0]                s_update_req_index,
   input  logic                               s_update_req_index_valid,
   output logic                               s_update_req_index_ready,
   input  logic [VALUE_SIZE-1:0]              s_update_req_data,
   input  logic                               s_update_req_data_valid,
   output logic                               s_update_req_data_ready,
   output logic [KEY_SIZE-1:0]                m_req_index,
   output logic [VALUE_SIZE-1:0]              m_req_data,
   output logic                               m_req_op,
   output logic                               m_req_valid,
   input  logic                               m_req_ready,
   input  logic [VALUE_SIZE-1:0]              m_rsp_data,
   input  logic                               m_rsp_valid,
   output logic                               m_rsp_ready,
   output logic [31:0]                        stat_lookup_cnt,
   output logic [31:0]                        stat_update_cnt,
   output logic [31:0]                        stat_stall_cnt
);

   localparam int PW = (LOOKUP_PORTS > 1) ? $clog2(LOOKUP_PORTS) : 1;
   localparam int AW = $clog2(MAX_OUTSTANDING);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(UPD_STARVE_LIMIT + 1);

   logic                  or_valid_q, or_valid_d;
   logic [KEY_SIZE-1:0]   or_index_q, or_index_d;
   logic [VALUE_SIZE-1:0] or_data_q, or_data_d;
   logic                  or_op_q, or_op_d;
   logic [PW-1:0]         rr_q, rr_d;
   logic [SW-1:0]         starve_q, starve_d;
   logic [PW-1:0]         tag_mem_q [MAX_OUTSTANDING];
   logic [PW-1:0]         tag_mem_d [MAX_OUTSTANDING];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic          can_load, upd_elig, any_lk, grant_upd, grant_lk, fifo_empty, pop;
   logic [PW-1:0] lk_win, head;
   logic [KEY_SIZE-1:0] lk_index;

   always_comb begin
      can_load   = !or_valid_q || m_req_ready;
      upd_elig   = s_update_req_index_valid && s_update_req_data_valid;
      any_lk     = 1'b0;
      lk_win     = '0;
      lk_index   = '0;
      // Scan ports starting at rr_q so the first eligible port at or after the pointer wins.
      for (int unsigned k = 0; k < LOOKUP_PORTS; k++) begin
         int unsigned p;
         p = int'(rr_q) + k;
         if (p >= LOOKUP_PORTS) p = p - LOOKUP_PORTS;
         if (!any_lk && s_lookup_req_valid[LOOKUP_PORTS-1-p] &&
             (cnt_q < CW'(MAX_OUTSTANDING))) begin
            any_lk = 1'b1;
            lk_win = PW'(p);
         end
      end
      for (int unsigned i = 0; i < LOOKUP_PORTS; i++)
         if (lk_win == PW'(i)) lk_index = s_lookup_req_index[(LOOKUP_PORTS-i)*KEY_SIZE-1 -: KEY_SIZE];

      grant_upd = !rst && can_load && upd_elig && (!any_lk || starve_q == SW'(UPD_STARVE_LIMIT));
      grant_lk  = !rst && can_load && any_lk && !grant_upd;

      s_lookup_req_ready = '0;
      for (int unsigned i = 0; i < LOOKUP_PORTS; i++)
         if (grant_lk && lk_win == PW'(i)) s_lookup_req_ready[LOOKUP_PORTS-1-i] = 1'b1;
      s_update_req_index_ready = grant_upd;
      s_update_req_data_ready  = grant_upd;

      or_valid_d = or_valid_q;
      or_index_d = or_index_q;
      or_data_d  = or_data_q;
      or_op_d    = or_op_q;
      if (can_load) begin
         or_valid_d = grant_upd || grant_lk;
         if (grant_upd) begin
            or_index_d = s_update_req_index;
            or_data_d  = s_update_req_data;
            or_op_d    = 1'b1;
         end else if (grant_lk) begin
            or_index_d = lk_index;
            or_data_d  = '0;
            or_op_d    = 1'b0;
         end
      end

      rr_d = rr_q;
      if (grant_lk) rr_d = (lk_win == PW'(LOOKUP_PORTS-1)) ? '0 : lk_win + 1'b1;

      starve_d = starve_q;
      if (!upd_elig || grant_upd) starve_d = '0;
      else if (grant_lk && starve_q != SW'(UPD_STARVE_LIMIT)) starve_d = starve_q + 1'b1;
   end

   // Response steering: the FIFO head names the port that owns the next in-order response.
   always_comb begin
      fifo_empty           = (cnt_q == '0);
      head                 = tag_mem_q[rd_ptr_q];
      m_rsp_ready          = 1'b0;
      s_lookup_value_valid = '0;
      for (int unsigned i = 0; i < LOOKUP_PORTS; i++) begin
         if (!fifo_empty && head == PW'(i)) begin
            m_rsp_ready                            = s_lookup_value_ready[LOOKUP_PORTS-1-i];
            s_lookup_value_valid[LOOKUP_PORTS-1-i] = m_rsp_valid;
         end
      end
      pop = m_rsp_valid && m_rsp_ready;

      tag_mem_d = tag_mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      if (grant_lk) begin
         tag_mem_d[wr_ptr_q] = lk_win;
         wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (grant_lk && !pop) cnt_d = cnt_q + 1'b1;
      else if (!grant_lk && pop) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         or_valid_q <= 1'b0;
         or_index_q <= '0;
         or_data_q  <= '0;
         or_op_q    <= 1'b0;
         rr_q       <= '0;
         starve_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) tag_mem_q[i] <= '0;
      end else begin
         or_valid_q <= or_valid_d;
         or_index_q <= or_index_d;
         or_data_q  <= or_data_d;
         or_op_q    <= or_op_d;
         rr_q       <= rr_d;
         starve_q   <= starve_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         tag_mem_q  <= tag_mem_d;
      end
   end

   assign m_req_valid         = or_valid_q;
   assign m_req_index         = or_index_q;
   assign m_req_data          = or_data_q;
   assign m_req_op            = or_op_q;
   assign s_lookup_value_data = {LOOKUP_PORTS{m_rsp_data}};

`ifdef TABLE_SCHED_STATS_EN
   logic [31:0] stat_lk_q, stat_lk_d, stat_upd_q, stat_upd_d, stat_stall_q, stat_stall_d;
   logic        any_req;

   always_comb begin
      any_req      = (|s_lookup_req_valid) || s_update_req_index_valid || s_update_req_data_valid;
      stat_lk_d    = stat_lk_q + {31'd0, grant_lk};
      stat_upd_d   = stat_upd_q + {31'd0, grant_upd};
      stat_stall_d = stat_stall_q + {31'd0, any_req && !grant_lk && !grant_upd};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_lk_q    <= '0;
         stat_upd_q   <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_lk_q    <= stat_lk_d;
         stat_upd_q   <= stat_upd_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_lookup_cnt = stat_lk_q;
   assign stat_update_cnt = stat_upd_q;
   assign stat_stall_cnt  = stat_stall_q;
`else
   assign stat_lookup_cnt = '0;
   assign stat_update_cnt = '0;
   assign stat_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_table_port_scheduler.sv
// Randomized scoreboard bench for table_port_scheduler: a queue-based reference model predicts
// grants and response steering; monitors pop expected backend requests and requester responses.
module tb_table_port_scheduler;
   localparam int KS  = 16;
   localparam int VS  = 32;
   localparam int LP  = 2;
   localparam int MO  = 4;
   localparam int LIM = 8;

   logic                clk, rst;
   logic [LP*KS-1:0]    s_lookup_req_index;
   logic [LP-1:0]       s_lookup_req_valid, s_lookup_req_ready;
   logic [LP*VS-1:0]    s_lookup_value_data;
   logic [LP-1:0]       s_lookup_value_valid, s_lookup_value_ready;
   logic [KS-1:0]       s_update_req_index;
   logic                s_update_req_index_valid, s_update_req_index_ready;
   logic [VS-1:0]       s_update_req_data;
   logic                s_update_req_data_valid, s_update_req_data_ready;
   logic [KS-1:0]       m_req_index;
   logic [VS-1:0]       m_req_data;
   logic                m_req_op, m_req_valid, m_req_ready;
   logic [VS-1:0]       m_rsp_data;
   logic                m_rsp_valid, m_rsp_ready;
   logic [31:0]         stat_lookup_cnt, stat_update_cnt, stat_stall_cnt;

   table_port_scheduler #(
      .KEY_SIZE(KS), .VALUE_SIZE(VS), .LOOKUP_PORTS(LP),
      .MAX_OUTSTANDING(MO), .UPD_STARVE_LIMIT(LIM)
   ) dut (
      .clk(clk), .rst(rst),
      .s_lookup_req_index(s_lookup_req_index), .s_lookup_req_valid(s_lookup_req_valid),
      .s_lookup_req_ready(s_lookup_req_ready), .s_lookup_value_data(s_lookup_value_data),
      .s_lookup_value_valid(s_lookup_value_valid), .s_lookup_value_ready(s_lookup_value_ready),
      .s_update_req_index(s_update_req_index), .s_update_req_index_valid(s_update_req_index_valid),
      .s_update_req_index_ready(s_update_req_index_ready), .s_update_req_data(s_update_req_data),
      .s_update_req_data_valid(s_update_req_data_valid), .s_update_req_data_ready(s_update_req_data_ready),
      .m_req_index(m_req_index), .m_req_data(m_req_data), .m_req_op(m_req_op),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
      .m_rsp_data(m_rsp_data), .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
      .stat_lookup_cnt(stat_lookup_cnt), .stat_update_cnt(stat_update_cnt),
      .stat_stall_cnt(stat_stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct { bit op; logic [KS-1:0] idx; logic [VS-1:0] data; } req_t;
   typedef struct { int port; logic [VS-1:0] data; } rsp_t;

   req_t          req_exp_q[$];
   rsp_t          rsp_exp_q[$];
   int            tag_q[$];
   logic [KS-1:0] be_q[$];

   bit          m_or_full;
   int          m_rr, m_starve;
   int unsigned m_lk, m_upd, m_stall;
   int unsigned n_checks, n_pass;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [VS-1:0] rsp_of(input logic [KS-1:0] k);
      return {k ^ 16'hA5A5, k};
   endfunction

   function automatic logic [KS-1:0] port_key(input int p);
      return s_lookup_req_index[(LP-p)*KS-1 -: KS];
   endfunction

   // Reference model: applies the arbitration and steering rules to the current inputs each cycle.
   always @(negedge clk) begin : model
      int   win, head;
      bit   upd_ok, can_load, g_upd, g_lk, any_req;
      logic [LP-1:0] exp_lrdy, exp_vv;
      bit   exp_mrr;
      if (rst) begin
         tag_q.delete(); req_exp_q.delete(); rsp_exp_q.delete();
         m_or_full = 0; m_rr = 0; m_starve = 0; m_lk = 0; m_upd = 0; m_stall = 0;
      end else begin
         win = -1;
         for (int k = 0; k < LP; k++)
            if (win < 0 && s_lookup_req_valid[LP-1-((m_rr+k)%LP)] && tag_q.size() < MO)
               win = (m_rr + k) % LP;
         upd_ok   = s_update_req_index_valid && s_update_req_data_valid;
         can_load = !m_or_full || m_req_ready;
         g_upd    = can_load && upd_ok && (win < 0 || m_starve == LIM);
         g_lk     = can_load && win >= 0 && !g_upd;
         exp_lrdy = '0;
         if (g_lk) exp_lrdy[LP-1-win] = 1'b1;
         exp_vv  = '0;
         exp_mrr = 0;
         head    = (tag_q.size() > 0) ? tag_q[0] : -1;
         if (head >= 0) begin
            exp_mrr = s_lookup_value_ready[LP-1-head];
            exp_vv[LP-1-head] = m_rsp_valid;
         end
         check("lookup_req_ready", 64'(s_lookup_req_ready), 64'(exp_lrdy));
         check("update_ready", 64'({s_update_req_index_ready, s_update_req_data_ready}), 64'({g_upd, g_upd}));
         check("m_rsp_ready", 64'(m_rsp_ready), 64'(exp_mrr));
         check("lookup_value_valid", 64'(s_lookup_value_valid), 64'(exp_vv));
`ifdef TABLE_SCHED_STATS_EN
         check("stat_lookup", 64'(stat_lookup_cnt), 64'(m_lk));
         check("stat_update", 64'(stat_update_cnt), 64'(m_upd));
         check("stat_stall", 64'(stat_stall_cnt), 64'(m_stall));
`else
         check("stat_zero", 64'({stat_lookup_cnt, stat_update_cnt | stat_stall_cnt}), 64'd0);
`endif
         if (m_rsp_valid && exp_mrr) void'(tag_q.pop_front());
         if (g_upd) begin
            req_exp_q.push_back('{op: 1'b1, idx: s_update_req_index, data: s_update_req_data});
            m_starve = 0;
            m_upd++;
         end else if (g_lk) begin
            req_exp_q.push_back('{op: 1'b0, idx: port_key(win), data: '0});
            rsp_exp_q.push_back('{port: win, data: rsp_of(port_key(win))});
            tag_q.push_back(win);
            m_rr = (win + 1) % LP;
            m_lk++;
            if (upd_ok && m_starve < LIM) m_starve++;
         end
         if (!upd_ok) m_starve = 0;
         if (can_load) m_or_full = g_upd || g_lk;
         any_req = (|s_lookup_req_valid) || s_update_req_index_valid || s_update_req_data_valid;
         if (any_req && !g_upd && !g_lk) m_stall++;
      end
   end

   always @(negedge clk) begin : monitor
      req_t e;
      rsp_t r;
      logic [LP-1:0] fired, exp_fired;
      if (!rst) begin
         if (m_req_valid && m_req_ready) begin
            if (req_exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL req_unexpected: got op=%0d idx=%0h, expected none", m_req_op, m_req_index);
            end else begin
               e = req_exp_q.pop_front();
               check("req_op", 64'(m_req_op), 64'(e.op));
               check("req_index", 64'(m_req_index), 64'(e.idx));
               if (e.op) check("req_data", 64'(m_req_data), 64'(e.data));
            end
         end
         fired = s_lookup_value_valid & s_lookup_value_ready;
         if (|fired) begin
            if (rsp_exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL rsp_unexpected: got fired=%0b, expected none", fired);
            end else begin
               r = rsp_exp_q.pop_front();
               exp_fired = '0;
               exp_fired[LP-1-r.port] = 1'b1;
               check("rsp_port", 64'(fired), 64'(exp_fired));
               check("rsp_data", 64'(s_lookup_value_data[(LP-r.port)*VS-1 -: VS]), 64'(r.data));
            end
         end
      end
   end

   // Backend: answers accepted lookups in order with rsp_of(index).
   always @(negedge clk) begin : backend
      if (rst) be_q.delete();
      else begin
         if (m_rsp_valid && m_rsp_ready) void'(be_q.pop_front());
         if (m_req_valid && m_req_ready && !m_req_op) be_q.push_back(m_req_index);
      end
   end

   task automatic drive(input int p_lv, input int p_uv, input int p_mr, input int p_rsp, input int p_vr);
      for (int i = 0; i < LP; i++) begin
         s_lookup_req_valid[LP-1-i] = ($urandom_range(99) < p_lv);
         s_lookup_req_index[(LP-i)*KS-1 -: KS] = KS'($urandom_range(63));
         s_lookup_value_ready[LP-1-i] = ($urandom_range(99) < p_vr);
      end
      s_update_req_index_valid = ($urandom_range(99) < p_uv);
      s_update_req_data_valid  = ($urandom_range(99) < p_uv);
      s_update_req_index       = KS'($urandom);
      s_update_req_data        = $urandom;
      m_req_ready              = ($urandom_range(99) < p_mr);
      m_rsp_data               = $urandom;
      m_rsp_valid              = 1'b0;
      if (be_q.size() > 0) begin
         if ($urandom_range(99) < p_rsp) begin
            m_rsp_valid = 1'b1;
            m_rsp_data  = rsp_of(be_q[0]);
         end
      end else if (tag_q.size() == 0 && $urandom_range(99) < 10) begin
         m_rsp_valid = 1'b1;  // stray response with nothing outstanding
      end
   endtask

   task automatic run(input int n, input int p_lv, input int p_uv, input int p_mr, input int p_rsp, input int p_vr);
      repeat (n) begin
         @(posedge clk); #1;
         drive(p_lv, p_uv, p_mr, p_rsp, p_vr);
      end
   endtask

   initial begin
      bit done;
      clk = 0; rst = 1;
      n_checks = 0; n_pass = 0;
      s_lookup_req_index = '0; s_lookup_req_valid = '0; s_lookup_value_ready = '0;
      s_update_req_index = '0; s_update_req_index_valid = 0; s_update_req_data = '0;
      s_update_req_data_valid = 0; m_req_ready = 0; m_rsp_data = '0; m_rsp_valid = 0;
      #7;
      check("reset_m_req_valid", 64'(m_req_valid), 64'd0);
      check("reset_stats", 64'({stat_lookup_cnt, stat_update_cnt | stat_stall_cnt}), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 0;

      run(400, 95, 85, 100, 100, 100);
      run(400, 70, 40, 50, 30, 60);
      run(300, 50, 50, 80, 70, 40);

      // Build up outstanding lookups with a pending request, then reset mid-transaction.
      done = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(posedge clk); #1;
         drive(90, 20, 30, 0, 100);
         done = (tag_q.size() >= 3) && m_req_valid;
      end
      #2 rst = 1;
      #1;
      check("rst_m_req_valid", 64'(m_req_valid), 64'd0);
      check("rst_lookup_ready", 64'(s_lookup_req_ready), 64'd0);
      check("rst_update_ready", 64'({s_update_req_index_ready, s_update_req_data_ready}), 64'd0);
      check("rst_value_valid", 64'(s_lookup_value_valid), 64'd0);
      check("rst_m_rsp_ready", 64'(m_rsp_ready), 64'd0);
      check("rst_stats", 64'({stat_lookup_cnt, stat_update_cnt | stat_stall_cnt}), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      drive(100, 0, 100, 0, 100);

      run(300, 80, 60, 90, 60, 80);
      run(200, 100, 100, 100, 100, 100);

      done = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(posedge clk); #1;
         drive(0, 0, 100, 100, 100);
         done = (tag_q.size() == 0) && (req_exp_q.size() == 0) && !m_req_valid;
      end
      if (!done) begin
         n_checks++;
         $display("FAIL drain_timeout: got %0d tags outstanding, expected 0", tag_q.size());
      end
      @(negedge clk); #1;
      check("rsp_queue_drained", 64'(rsp_exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
